proc_seq_ctrl: RTL and testbench

Parametrised multi-cycle sequencer for the processor control path. It replaces the fixed five-state control cycle with one that adds:
- a variable-latency memory handshake, with a wait-state timeout;
- optional skipping of the MEM state for non-memory instructions;
- a halt state;
- a retired-instruction counter.

It sits between the instruction register / memory interface and the data path. It drives the sequencing strobes and the ALU opcode; the data-path mux selects stay in the data path's own decode.

---
 rtl/proc_seq_if.sv | 59 +++++
 rtl/proc_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_proc_seq_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/proc_seq_if.sv
// Bus bundle between the control sequencer and its surroundings.
// master = sequencer side, slave = IR/memory/data-path side.
interface proc_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] INSTRUCTION;
    logic                  ZERO;
    logic                  MEM_ACK;
    logic                  HALT;

    logic [2:0]            STATE;
    logic                  IR_LOAD;
    logic                  REG_R;
    logic                  REG_W;
    logic                  PC_LOAD;
    logic                  PC_BRANCH;
    logic                  READ;
    logic                  WRITE;
    logic [5:0]            ALU_OPRN;
    logic                  FAULT;
    logic [CNT_WIDTH-1:0]  INSTR_COUNT;

    modport master (
        input  INSTRUCTION,
        input  ZERO,
        input  MEM_ACK,
        input  HALT,
        output STATE,
        output IR_LOAD,
        output REG_R,
        output REG_W,
        output PC_LOAD,
        output PC_BRANCH,
        output READ,
        output WRITE,
        output ALU_OPRN,
        output FAULT,
        output INSTR_COUNT
    );

    modport slave (
        output INSTRUCTION,
        output ZERO,
        output MEM_ACK,
        output HALT,
        input  STATE,
        input  IR_LOAD,
        input  REG_R,
        input  REG_W,
        input  PC_LOAD,
        input  PC_BRANCH,
        input  READ,
        input  WRITE,
        input  ALU_OPRN,
        input  FAULT,
        input  INSTR_COUNT
    );
endinterface

// File: rtl/proc_seq_ctrl.sv
// Multi-cycle control sequencer: fetch/decode/exe/mem/wb with
// memory wait timeout, optional MEM skip, halt and retire counter.
module proc_seq_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_WAIT_MAX = 15,
    parameter bit SKIP_MEM     = 1'b1,
    parameter int CNT_WIDTH    = 16
) (
    input logic        CLK,
    input logic        RST,
    proc_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXE    = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_UNUSED = 3'b101,
        S_HALTED = 3'b110,
        S_FAULT  = 3'b111
    } state_t;

    localparam int WW = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_PUSH  = 6'h1b;
    localparam logic [5:0] OP_POP   = 6'h1c;
    localparam logic [5:0] OP_MULI  = 6'h1d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t                state;
    state_t                nxt;
    logic                  run;
    logic [5:0]            op_q;
    logic [5:0]            fn_q;
    logic [5:0]            alu_q;
    logic [WW-1:0]         wcnt;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  rd_q, wr_q, rr_q, rw_q, pcl_q, flt_q;
    logic                  rd_n, wr_n, rr_n, rw_n, pcl_n, flt_n;
    logic                  req;
    logic                  timeout;
    logic [5:0]            op_in;
    logic [5:0]            fn_in;
    logic                  unused_bits;

    assign op_in = bus.INSTRUCTION[DATA_WIDTH-1 -: 6];
    assign fn_in = bus.INSTRUCTION[5:0];
    assign unused_bits = ^bus.INSTRUCTION[DATA_WIDTH-7:6];

    function automatic logic [5:0] alu_map(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        logic [5:0] r;
        r = 6'h00;
        if (op == OP_RTYPE) begin
            case (fn)
                6'h20:   r = 6'h01;
                6'h22:   r = 6'h02;
                6'h2c:   r = 6'h03;
                6'h02:   r = 6'h04;
                6'h01:   r = 6'h05;
                6'h24:   r = 6'h06;
                6'h25:   r = 6'h07;
                6'h27:   r = 6'h08;
                6'h2a:   r = 6'h09;
                default: r = 6'h00;
            endcase
        end else begin
            case (op)
                OP_ADDI: r = 6'h01;
                OP_MULI: r = 6'h03;
                OP_ANDI: r = 6'h06;
                OP_ORI:  r = 6'h07;
                OP_SLTI: r = 6'h09;
                OP_BEQ:  r = 6'h02;
                OP_BNE:  r = 6'h02;
                OP_LW:   r = 6'h01;
                OP_SW:   r = 6'h01;
                OP_PUSH: r = 6'h02;
                OP_POP:  r = 6'h01;
                default: r = 6'h00;
            endcase
        end
        return r;
    endfunction

    function automatic logic is_rd(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_POP);
    endfunction

    function automatic logic is_wr(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_PUSH);
    endfunction

    function automatic logic writes_reg(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        logic r;
        r = 1'b0;
        unique case (1'b1)
            op == OP_RTYPE: r = (fn != FN_JR);
            op == OP_ADDI,
            op == OP_MULI,
            op == OP_ANDI,
            op == OP_ORI,
            op == OP_LUI,
            op == OP_SLTI,
            op == OP_LW,
            op == OP_POP,
            op == OP_JAL:   r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // A request is outstanding exactly while READ or WRITE is driven.
    assign req     = rd_q | wr_q;
    assign timeout = req & ~bus.MEM_ACK & (wcnt == WAIT_LAST);

    always_comb begin
        nxt   = state;
        rd_n  = 1'b0;
        wr_n  = 1'b0;
        rr_n  = 1'b0;
        rw_n  = 1'b0;
        pcl_n = 1'b0;
        flt_n = 1'b0;
        if (run) begin
            case (state)
                S_FETCH: begin
                    if (req && bus.MEM_ACK)
                        nxt = S_DECODE;
                    else if (timeout)
                        nxt = S_FAULT;
                end
                S_DECODE: nxt = S_EXE;
                S_EXE: begin
                    if (!SKIP_MEM || is_rd(op_q) || is_wr(op_q))
                        nxt = S_MEM;
                    else
                        nxt = S_WB;
                end
                S_MEM: begin
                    if (!req || bus.MEM_ACK)
                        nxt = S_WB;
                    else if (timeout)
                        nxt = S_FAULT;
                end
                S_WB:     nxt = bus.HALT ? S_HALTED : S_FETCH;
                S_HALTED: nxt = bus.HALT ? S_HALTED : S_FETCH;
                S_FAULT:  nxt = S_FAULT;
                default:  nxt = S_FETCH;
            endcase
        end
        // Outputs are registered from the state being entered.
        rd_n  = (nxt == S_FETCH) ||
                ((nxt == S_MEM) && is_rd(op_q));
        wr_n  = (nxt == S_MEM) && is_wr(op_q);
        rr_n  = (nxt == S_DECODE);
        rw_n  = (nxt == S_WB) && writes_reg(op_q, fn_q);
        pcl_n = (nxt == S_WB);
        flt_n = (nxt == S_FAULT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            run   <= 1'b0;
            state <= S_FETCH;
        end else begin
            run   <= 1'b1;
            state <= nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            rr_q  <= 1'b0;
            rw_q  <= 1'b0;
            pcl_q <= 1'b0;
            flt_q <= 1'b0;
        end else begin
            rd_q  <= rd_n;
            wr_q  <= wr_n;
            rr_q  <= rr_n;
            rw_q  <= rw_n;
            pcl_q <= pcl_n;
            flt_q <= flt_n;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_q <= 6'h00;
            op_q  <= 6'h00;
            fn_q  <= 6'h00;
        end else if (state == S_DECODE) begin
            alu_q <= alu_map(op_in, fn_in);
            op_q  <= op_in;
            fn_q  <= fn_in;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            cnt_q <= '0;
        else if (state == S_WB)
            cnt_q <= cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            wcnt <= '0;
        else if ((nxt != state) &&
                 ((nxt == S_FETCH) || (nxt == S_MEM)))
            wcnt <= '0;
        else if (req && !bus.MEM_ACK &&
                 ((state == S_FETCH) || (state == S_MEM)))
            wcnt <= wcnt + 1'b1;
    end

    assign bus.STATE       = state;
    assign bus.IR_LOAD     = (state == S_FETCH) & rd_q & bus.MEM_ACK;
    assign bus.PC_BRANCH   = (state == S_WB) &
                             (((op_q == OP_BEQ) & bus.ZERO) |
                              ((op_q == OP_BNE) & ~bus.ZERO));
    assign bus.REG_R       = rr_q;
    assign bus.REG_W       = rw_q;
    assign bus.PC_LOAD     = pcl_q;
    assign bus.READ        = rd_q;
    assign bus.WRITE       = wr_q;
    assign bus.ALU_OPRN    = alu_q;
    assign bus.FAULT       = flt_q;
    assign bus.INSTR_COUNT = cnt_q;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Directed bench for proc_seq_ctrl: SKIP_MEM=1 unit (a) and
// SKIP_MEM=0 / 4-bit counter unit (b) sharing the same inputs.
module tb_proc_seq_ctrl;

    localparam logic [2:0] F = 3'b000;
    localparam logic [2:0] D = 3'b001;
    localparam logic [2:0] E = 3'b010;
    localparam logic [2:0] M = 3'b011;
    localparam logic [2:0] W = 3'b100;
    localparam logic [2:0] H = 3'b110;
    localparam logic [2:0] X = 3'b111;

    typedef struct packed {
        logic [2:0] st;
        logic       irl;
        logic       rr;
        logic       rw;
        logic       pcl;
        logic       pcb;
        logic       rd;
        logic       wr;
        logic [5:0] alu;
        logic       flt;
    } obs_t;

    logic CLK;
    logic RST;
    int   total = 0;
    int   bad = 0;
    obs_t q[$];
    string tq[$];
    logic [5:0] prev_alu[2];
    int   ecnt[2];

    proc_seq_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) ia();
    proc_seq_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  ib();

    assign ib.INSTRUCTION = ia.INSTRUCTION;
    assign ib.ZERO        = ia.ZERO;
    assign ib.MEM_ACK     = ia.MEM_ACK;
    assign ib.HALT        = ia.HALT;

    proc_seq_ctrl #(
        .DATA_WIDTH(32), .MEM_WAIT_MAX(15),
        .SKIP_MEM(1'b1), .CNT_WIDTH(16)
    ) dut_a (.CLK(CLK), .RST(RST), .bus(ia.master));

    proc_seq_ctrl #(
        .DATA_WIDTH(32), .MEM_WAIT_MAX(15),
        .SKIP_MEM(1'b0), .CNT_WIDTH(4)
    ) dut_b (.CLK(CLK), .RST(RST), .bus(ib.master));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    obs_t oa, ob;
    assign oa = {ia.STATE, ia.IR_LOAD, ia.REG_R, ia.REG_W,
                 ia.PC_LOAD, ia.PC_BRANCH, ia.READ, ia.WRITE,
                 ia.ALU_OPRN, ia.FAULT};
    assign ob = {ib.STATE, ib.IR_LOAD, ib.REG_R, ib.REG_W,
                 ib.PC_LOAD, ib.PC_BRANCH, ib.READ, ib.WRITE,
                 ib.ALU_OPRN, ib.FAULT};

    function automatic obs_t ex(
        input logic [2:0] st, input logic irl, input logic rr,
        input logic rw, input logic pcl, input logic pcb,
        input logic rd, input logic wr, input logic [5:0] alu,
        input logic flt
    );
        return {st, irl, rr, rw, pcl, pcb, rd, wr, alu, flt};
    endfunction

    // One clock cycle: expectation queued, DUT sampled, then advance.
    task automatic chk(input bit sel, input string tag, input obs_t e);
        obs_t o, x;
        string t;
        q.push_back(e);
        tq.push_back(tag);
        #1;
        o = sel ? ob : oa;
        x = q.pop_front();
        t = tq.pop_front();
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, o, x);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_cnt(input bit sel, input string tag);
        logic [15:0] o, x;
        o = sel ? {12'b0, ib.INSTR_COUNT} : ia.INSTR_COUNT;
        x = sel ? 16'(ecnt[1] % 16) : 16'(ecnt[0] % 65536);
        total++;
        assert (o === x) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, x);
        end
    endtask

    task automatic do_reset(input bit sel);
        RST = 1'b0;
        ia.MEM_ACK = 1'b1;
        ia.HALT = 1'b0;
        ia.ZERO = 1'b0;
        prev_alu[0] = 6'h00;
        prev_alu[1] = 6'h00;
        ecnt[0] = 0;
        ecnt[1] = 0;
        chk(sel, "reset", ex(F, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0));
        chk_cnt(sel, "reset_cnt");
        chk(sel, "reset_hold", ex(F, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0));
        RST = 1'b1;
        chk(sel, "release", ex(F, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0));
    endtask

    task automatic instr(
        input bit sel, input string tag, input logic [31:0] ins,
        input logic zero, input int mdly, input bit halt,
        input logic [5:0] alu, input bit rw, input bit visit,
        input bit mrd, input bit mwr, input bit pcb
    );
        logic [5:0] pa;
        pa = prev_alu[sel];
        ia.INSTRUCTION = ins;
        ia.MEM_ACK = 1'b1;
        ia.HALT = 1'b0;
        ia.ZERO = ~zero;
        chk(sel, {tag, ".fetch"}, ex(F, 1, 0, 0, 0, 0, 1, 0, pa, 0));
        chk(sel, {tag, ".decode"}, ex(D, 0, 1, 0, 0, 0, 0, 0, pa, 0));
        ia.HALT = halt;
        chk(sel, {tag, ".exe"}, ex(E, 0, 0, 0, 0, 0, 0, 0, alu, 0));
        if (visit) begin
            for (int i = 0; i <= mdly; i++) begin
                ia.MEM_ACK = (mrd | mwr) && (i == mdly);
                chk(sel, {tag, ".mem"},
                    ex(M, 0, 0, 0, 0, 0, mrd, mwr, alu, 0));
            end
        end
        ia.ZERO = zero;
        ia.MEM_ACK = 1'b1;
        chk(sel, {tag, ".wb"}, ex(W, 0, 0, rw, 1, pcb, 0, 0, alu, 0));
        prev_alu[sel] = alu;
        ecnt[sel]++;
        chk_cnt(sel, {tag, ".cnt"});
        if (halt) begin
            chk(sel, {tag, ".halted"},
                ex(H, 0, 0, 0, 0, 0, 0, 0, alu, 0));
            ia.HALT = 1'b0;
            chk(sel, {tag, ".halt_rel"},
                ex(H, 0, 0, 0, 0, 0, 0, 0, alu, 0));
        end
    endtask

    logic [31:0] tins[11] = '{
        32'h00000024, 32'h00000025, 32'h00000027, 32'h0000002a,
        32'h00000002, 32'h00000001, 32'h0000002c, 32'h30000000,
        32'h28000000, 32'h74000000, 32'h3C000000
    };
    logic [5:0] talu[11] = '{
        6'h06, 6'h07, 6'h08, 6'h09, 6'h04, 6'h05, 6'h03, 6'h06,
        6'h09, 6'h03, 6'h00
    };

    initial begin
        RST = 1'b1;
        ia.INSTRUCTION = 32'h0;
        ia.MEM_ACK = 1'b0;
        ia.HALT = 1'b0;
        ia.ZERO = 1'b0;
        @(posedge CLK);
        #1;

        // unit a: SKIP_MEM=1
        do_reset(0);
        instr(0, "add", 32'h00000020, 0, 0, 0, 6'h01, 1, 0, 0, 0, 0);
        instr(0, "lw", 32'h8C000004, 0, 3, 0, 6'h01, 1, 1, 1, 0, 0);
        instr(0, "beq_z1", 32'h10000000, 1, 0, 0, 6'h02, 0, 0, 0, 0, 1);
        instr(0, "beq_z0", 32'h10000000, 0, 0, 0, 6'h02, 0, 0, 0, 0, 0);
        instr(0, "bne_z0", 32'h14000000, 0, 0, 0, 6'h02, 0, 0, 0, 0, 1);
        instr(0, "ori_halt", 32'h34000000, 0, 0, 1, 6'h07, 1, 0, 0, 0, 0);
        instr(0, "jr", 32'h03E00008, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        instr(0, "sw", 32'hAC000000, 0, 0, 0, 6'h01, 0, 1, 0, 1, 0);
        instr(0, "jal", 32'h0C000000, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0);
        instr(0, "unk", 32'hFC000000, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0);

        // reset while a load is waiting in MEM
        ia.INSTRUCTION = 32'h8C000000;
        ia.MEM_ACK = 1'b1;
        chk(0, "mr.fetch", ex(F, 1, 0, 0, 0, 0, 1, 0, 6'h00, 0));
        chk(0, "mr.decode", ex(D, 0, 1, 0, 0, 0, 0, 0, 6'h00, 0));
        chk(0, "mr.exe", ex(E, 0, 0, 0, 0, 0, 0, 0, 6'h01, 0));
        ia.MEM_ACK = 1'b0;
        chk(0, "mr.mem", ex(M, 0, 0, 0, 0, 0, 1, 0, 6'h01, 0));
        RST = 1'b0;
        ecnt[0] = 0;
        chk(0, "mr.reset", ex(F, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0));
        chk_cnt(0, "mr.cnt");
        RST = 1'b1;
        chk(0, "mr.release", ex(F, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0));

        // fetch never acknowledged -> timeout after 15 cycles
        for (int i = 0; i < 15; i++)
            chk(0, "to.wait", ex(F, 0, 0, 0, 0, 0, 1, 0, 6'h00, 0));
        chk(0, "to.fault", ex(X, 0, 0, 0, 0, 0, 0, 0, 6'h00, 1));
        ia.MEM_ACK = 1'b1;
        ia.HALT = 1'b1;
        chk(0, "to.sticky1", ex(X, 0, 0, 0, 0, 0, 0, 0, 6'h00, 1));
        ia.HALT = 1'b0;
        chk(0, "to.sticky2", ex(X, 0, 0, 0, 0, 0, 0, 0, 6'h00, 1));
        RST = 1'b0;
        chk(0, "to.clear", ex(F, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0));

        // unit b: SKIP_MEM=0, 4-bit retire counter
        do_reset(1);
        instr(1, "b.sub", 32'h00000022, 0, 0, 0, 6'h02, 1, 1, 0, 0, 0);
        instr(1, "b.sw", 32'hAC000000, 0, 1, 0, 6'h01, 0, 1, 0, 1, 0);
        instr(1, "b.pop", 32'h70000000, 0, 2, 0, 6'h01, 1, 1, 1, 0, 0);
        instr(1, "b.push", 32'h6C000000, 0, 0, 0, 6'h02, 0, 1, 0, 1, 0);
        instr(1, "b.addi", 32'h20000000, 0, 0, 0, 6'h01, 1, 1, 0, 0, 0);
        for (int i = 0; i < 11; i++)
            instr(1, $sformatf("b.t%0d", i), tins[i], 0, 0, 0,
                  talu[i], 1, 1, 0, 0, 0);
        instr(1, "b.wrap", 32'h00000020, 0, 0, 0, 6'h01, 1, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
